// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// One N-bit ripple-carry slice is reused across WORDS slices, least
// significant first. The carry is registered between slices.
module mp_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   in_a,
  input  logic [N*WORDS-1:0]   in_b,
  input  logic                 in_sub,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Slice datapath signals
  logic [N-1:0]    a_sl, b_sl, s_sl;
  logic [N:0]      cv;

  // Ripple-carry slice over the currently selected operand slice
  always_comb begin
    a_sl  = a_q[int'(idx_q)*N +: N];
    b_sl  = b_q[int'(idx_q)*N +: N];
    s_sl  = '0;
    cv    = '0;
    cv[0] = carry_q;
    for (int unsigned i = 0; i < N; i++) begin
      s_sl[i]  = a_sl[i] ^ b_sl[i] ^ cv[i];
      cv[i+1]  = (a_sl[i] & b_sl[i]) | ((a_sl[i] ^ b_sl[i]) & cv[i]);
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*N +: N] = s_sl;
        carry_d                   = cv[N];
        if (idx_q == LAST_IDX) begin
          cout_d  = cv[N];
          // Carry into the word MSB is the carry into the slice MSB here
          ovf_d   = cv[N-1] ^ cv[N];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer.
- Time-multiplexes one N-bit ripple-carry adder slice (p = a^b, g = a&b, rippled carry) across WORDS slices of a WORDS*N-bit operand pair, least significant slice first.
- Carry is registered between slices, so arbitrarily wide adds run on a single narrow adder.
- Valid/ready on both input and output sides; sits between an operand producer and a result consumer.

Parameters:
- N, 8: adder slice width in bits, >= 1.
- WORDS, 4: number of slices, >= 1. Total operand width W = N*WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  1 = compute A - B, 0 = compute A + B + in_cin.
- in_cin  input  1  carry-in for add; ignored when in_sub = 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_cout  output  1  carry out of MSB. For subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE; slice index = 0.
  - Carry register, operand registers, out_sum, out_cout and out_ovf all go to 0.
  - out_valid = 0, busy = 0, in_ready = 1 once rst_n is high.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state != IDLE).
- IDLE:
  - Accept on the edge where in_valid & in_ready.
  - Latch A.
  - Latch B, inverted when in_sub = 1.
  - Latch the carry register as in_sub ? 1 : in_cin.
  - Set idx = 0 and go to RUN.
  - in_valid without acceptance has no effect; inputs are don't-care outside the accept edge.
- RUN, one slice per cycle:
  - Adder inputs: slice idx of A, slice idx of B', carry register.
  - On each edge, write the slice sum into out_sum[idx*N +: N] and load the carry register with the slice carry-out.
  - If idx == WORDS-1: on that edge set out_cout = slice carry-out, set out_ovf = (carry into bit W-1) XOR (carry out of bit W-1), and go to DONE. Otherwise idx increments.
  - Carry into bit W-1 = A[W-1] ^ B'[W-1] ^ sum[W-1].
  - RUN lasts exactly WORDS cycles.
- Latency: out_valid rises exactly WORDS cycles after the accept edge.
  - WORDS = 1: one RUN cycle, then DONE.
  - The index counter is at least 1 bit wide.
- DONE:
  - out_sum, out_cout and out_ovf stay stable while out_valid = 1 and out_ready = 0 (backpressure holds indefinitely).
  - On the edge with out_ready = 1, go to IDLE.
- No overlap:
  - A new request is accepted only in IDLE.
  - Peak throughput is one operation per WORDS+2 cycles: accept, WORDS RUN cycles, at least one DONE cycle.
- Output registers retain the last result after returning to IDLE; they are overwritten slice by slice during the next RUN.
- Consumers must sample out_sum only while out_valid = 1.
- Arithmetic is modulo 2^W. No saturation.

Test Plan (N = 8, WORDS = 4):
- Add with full carry ripple: A = 0xFFFFFFFF, B = 0x00000001, sub = 0, cin = 0 -> out_valid 4 cycles after accept; sum 0x00000000, cout 1, ovf 0.
- Signed overflow: A = 0x7FFFFFFF, B = 0x00000001, add -> sum 0x80000000, cout 0, ovf 1. A = 0x80000000, B = 0x80000000 -> sum 0, cout 1, ovf 1.
- Subtract with borrow: A = 5, B = 7, sub = 1, cin = 1 (ignored) -> sum 0xFFFFFFFE, cout 0, ovf 0. A = 7, B = 5 -> sum 2, cout 1.
- Carry-in and backpressure: A = 0x12345678, B = 0x0FEDCBA9, cin = 1 -> sum 0x22222222; out_ready held low 10 cycles -> outputs stable, in_ready 0; in_valid held high is not accepted until the cycle after the out_ready handshake.
- Reset mid-RUN: assert rst_n = 0 two cycles after accept -> out_valid, busy, out_sum and cout go to 0 immediately. After release, a fresh 1 + 1 yields sum 2 with correct latency.
- Back-to-back: two queued requests with out_ready tied to 1 -> accepts spaced exactly WORDS+2 = 6 cycles apart; both results correct.
